// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: the signals between fifo_rd_ctrl, the fifo_sync read port
// and the downstream stream consumer.
//   empty, out_data : fifo_sync read side (flag, read data one cycle after rd_en)
//   rd_en           : fifo_sync read strobe
//   m_data, m_valid : head word of the downstream stream
//   m_ready         : consumer accepts the word (transfer on m_valid && m_ready)
//   rd_count        : running transfer count, present only with FIFO_RD_CNT_EN
// master = the controller, slave = the FIFO/consumer side.
interface fifo_rd_ctrl_if #(
  parameter int unsigned DATA_W = 8
`ifdef FIFO_RD_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
);
  logic              empty;
  logic [DATA_W-1:0] out_data;
  logic              rd_en;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
`ifdef FIFO_RD_CNT_EN
  logic [CNT_W-1:0]  rd_count;
`endif

  modport master (
    input  empty, out_data, m_ready,
    output rd_en, m_data, m_valid
`ifdef FIFO_RD_CNT_EN
    , output rd_count
`endif
  );

  modport slave (
    output empty, out_data, m_ready,
    input  rd_en, m_data, m_valid
`ifdef FIFO_RD_CNT_EN
    , input rd_count
`endif
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller for fifo_sync. Drains the FIFO through a
// 3-entry prefetch buffer and presents the words as a valid/ready stream, so
// the FIFO's one-cycle read latency is hidden and rd_en never depends on
// m_ready.
//   clk  : rising-edge clock shared with fifo_sync
//   rst  : synchronous active-high reset shared with fifo_sync
//   bus  : fifo_rd_ctrl_if.master (empty/out_data/rd_en to the FIFO,
//          m_data/m_valid/m_ready to the consumer, optional rd_count)
// Optional feature macro: FIFO_RD_CNT_EN adds parameter CNT_W and the
// rd_count transfer counter (wraps modulo 2^CNT_W).
module fifo_rd_ctrl #(
  parameter int unsigned DATA_W = 8
`ifdef FIFO_RD_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            rst,
  fifo_rd_ctrl_if.master  bus
);

  // State encodes the number of buffered words (occ).
  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} occ_e;

  occ_e              state, state_n;
  logic              inflight;
  logic [DATA_W-1:0] mem   [3];
  logic [DATA_W-1:0] mem_n [3];
  logic [1:0]        head, head_n;
  logic [1:0]        tail, tail_n;
  logic              capture;
  logic              pop;
  logic [2:0]        load;
  logic              rd_en_c;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    capture = inflight;
    pop     = bus.m_valid && bus.m_ready;
    // Buffered plus in-flight words; a read is only issued when the word it
    // returns is guaranteed a free slot.
    load    = {1'b0, state} + {2'b00, inflight};
    rd_en_c = !rst && !bus.empty && (load < 3'd3);

    mem_n   = mem;
    head_n  = head;
    tail_n  = tail;
    state_n = state;

    if (capture) begin
      mem_n[tail] = bus.out_data;
      tail_n      = ptr_inc(tail);
    end
    if (pop) begin
      head_n = ptr_inc(head);
    end

    if (capture && !pop) begin
      unique case (state)
        S0:      state_n = S1;
        S1:      state_n = S2;
        default: state_n = S3;
      endcase
    end else if (pop && !capture) begin
      unique case (state)
        S3:      state_n = S2;
        S2:      state_n = S1;
        default: state_n = S0;
      endcase
    end
  end

  assign bus.rd_en = rd_en_c;

  // m_valid/m_data are registered from the next-state view so that a word
  // captured in the same cycle as a pop can become the new head immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S0;
      inflight    <= 1'b0;
      head        <= '0;
      tail        <= '0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state       <= state_n;
      inflight    <= rd_en_c;
      head        <= head_n;
      tail        <= tail_n;
      mem         <= mem_n;
      bus.m_valid <= (state_n != S0);
      bus.m_data  <= mem_n[head_n];
    end
  end

`ifdef FIFO_RD_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_count <= '0;
    end else if (pop) begin
      bus.rd_count <= bus.rd_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a small behavioural fifo_sync model.
module tb_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'd0;

  int unsigned checks = 0;
  int unsigned passes = 0;

`ifdef FIFO_RD_CNT_EN
  fifo_rd_ctrl_if #(.DATA_W(8), .CNT_W(8)) bus ();
  fifo_rd_ctrl #(.DATA_W(8), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus.master));
`else
  fifo_rd_ctrl_if #(.DATA_W(8)) bus ();
  fifo_rd_ctrl #(.DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus.master));
`endif

  always #5 clk = ~clk;

  // fifo_sync model: 256 deep, registered read data.
  logic [7:0] fmem [256];
  logic [7:0] fw, fr;
  logic [8:0] fcnt;

  assign bus.empty = (fcnt == 9'd0);

  always @(posedge clk) begin
    if (rst) begin
      fw   <= 8'd0;
      fr   <= 8'd0;
      fcnt <= 9'd0;
    end else begin
      if (wr_en) begin
        fmem[fw] <= wr_data;
        fw       <= fw + 8'd1;
      end
      if (bus.rd_en) begin
        bus.out_data <= fmem[fr];
        fr           <= fr + 8'd1;
      end
      fcnt <= fcnt + {8'd0, wr_en} - {8'd0, bus.rd_en};
    end
  end

  // Monitor, sampled on the falling edge.
  logic [7:0]  rx [$];
  int unsigned rx_cyc [$];
  int unsigned cyc = 0;
  int unsigned rd_pulses = 0;
  bit          underflow = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_valid && bus.m_ready) begin
        rx.push_back(bus.m_data);
        rx_cyc.push_back(cyc);
      end
      if (bus.rd_en) rd_pulses = rd_pulses + 1;
      if (bus.rd_en && bus.empty) underflow = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rx.delete();
    rx_cyc.delete();
    rd_pulses = 0;
    underflow = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic wait_rx(input int unsigned n, input int unsigned budget);
    for (int unsigned c = 0; c < budget && rx.size() < n; c++) tick();
  endtask

  task automatic test_reset();
    bus.m_ready = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (bus.rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", bus.rd_en);
    else passes++;
    tick();
    rst = 1'b0;
    clear_mon();
    checks++;
    if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", bus.m_valid);
    else passes++;
    checks++;
    if (bus.m_data !== 8'd0) $display("FAIL reset_m_data: got %0d want 0", bus.m_data);
    else passes++;
    checks++;
    if (bus.rd_en !== 1'b0) $display("FAIL reset_rd_en_idle: got %b want 0", bus.rd_en);
    else passes++;
  endtask

  task automatic test_basic_drain();
    logic [7:0] v [3];
    v[0] = 8'd56; v[1] = 8'd7; v[2] = 8'd41;
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = v[i];
      wr_en = 1'b1;
      tick();
      checks++;
      if (bus.m_valid !== (i == 2)) $display("FAIL basic_latency%0d: m_valid got %b want %b", i, bus.m_valid, (i == 2));
      else passes++;
    end
    wr_en = 1'b0;
    checks++;
    if (bus.m_data !== 8'd56) $display("FAIL basic_first_data: got %0d want 56", bus.m_data);
    else passes++;
    wait_rx(3, 10);
    tick();
    checks++;
    if (rx.size() != 3) $display("FAIL basic_count: got %0d want 3", rx.size());
    else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= rx.size() || rx[i] !== v[i])
        $display("FAIL basic_word%0d: got %0d want %0d", i, (i < rx.size()) ? rx[i] : 8'hxx, v[i]);
      else passes++;
    end
    checks++;
    if (bus.m_valid !== 1'b0) $display("FAIL basic_idle: m_valid got %b want 0", bus.m_valid);
    else passes++;
    checks++;
    if (underflow) $display("FAIL basic_underflow: rd_en seen with empty=1, want never");
    else passes++;
  endtask

  task automatic test_backpressure();
    bit stable;
    do_reset();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'((i + 1) * 10);
      wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    stable = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.m_valid !== 1'b1 || bus.m_data !== 8'd10) stable = 1'b0;
    end
    checks++;
    if (rd_pulses != 3) $display("FAIL bp_reads: got %0d want 3", rd_pulses);
    else passes++;
    checks++;
    if (bus.rd_en !== 1'b0) $display("FAIL bp_rd_en: got %b want 0", bus.rd_en);
    else passes++;
    checks++;
    if (!stable) $display("FAIL bp_stall_stable: got unstable m_data/m_valid want 10 held");
    else passes++;
    bus.m_ready = 1'b1;
    wait_rx(5, 30);
    checks++;
    if (rx.size() != 5) $display("FAIL bp_count: got %0d want 5", rx.size());
    else passes++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= rx.size() || rx[i] !== 8'((i + 1) * 10))
        $display("FAIL bp_word%0d: got %0d want %0d", i, (i < rx.size()) ? rx[i] : 8'hxx, (i + 1) * 10);
      else passes++;
    end
  endtask

  task automatic test_throughput();
    logic [7:0] v [8];
    int unsigned t0;
    v[0] = 8'd5; v[1] = 8'd12; v[2] = 8'd6; v[3] = 8'd8;
    v[4] = 8'd33; v[5] = 8'd1; v[6] = 8'd2; v[7] = 8'd3;
    do_reset();
    bus.m_ready = 1'b1;
    t0 = 0;
    for (int i = 0; i < 8; i++) begin
      wr_data = v[i];
      wr_en = 1'b1;
      tick();
      if (i == 0) t0 = cyc;
    end
    wr_en = 1'b0;
    wait_rx(8, 20);
    checks++;
    if (rx.size() != 8) $display("FAIL tp_count: got %0d want 8", rx.size());
    else passes++;
    if (rx.size() == 8) begin
      checks++;
      if (rx_cyc[0] != t0 + 2) $display("FAIL tp_startup: first transfer cycle %0d want %0d", rx_cyc[0], t0 + 2);
      else passes++;
      checks++;
      if (rx_cyc[7] - rx_cyc[0] != 7) $display("FAIL tp_rate: span %0d cycles want 7", rx_cyc[7] - rx_cyc[0]);
      else passes++;
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (rx[i] !== v[i]) $display("FAIL tp_word%0d: got %0d want %0d", i, rx[i], v[i]);
        else passes++;
      end
    end
  endtask

  task automatic test_random_stream();
    int unsigned bad;
    do_reset();
    bus.m_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          while ($urandom_range(0, 2) == 0) begin
            wr_en = 1'b0;
            tick();
          end
          wr_data = 8'((i * 37 + 11) & 255);
          wr_en = 1'b1;
          tick();
        end
        wr_en = 1'b0;
      end
      begin
        for (int c = 0; c < 6000 && rx.size() < 200; c++) begin
          bus.m_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    bus.m_ready = 1'b0;
    checks++;
    if (rx.size() != 200) $display("FAIL rand_count: got %0d want 200", rx.size());
    else passes++;
    bad = 0;
    for (int i = 0; i < 200 && i < rx.size(); i++) begin
      if (rx[i] !== 8'((i * 37 + 11) & 255)) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL rand_order: %0d words out of order want 0", bad);
    else passes++;
    checks++;
    if (underflow) $display("FAIL rand_underflow: rd_en seen with empty=1, want never");
    else passes++;
  endtask

  task automatic test_reset_mid();
    bit quiet;
    do_reset();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'(71 + i);
      wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    tick();
    // occ=2, one read in flight here
    checks++;
    if (rd_pulses != 3) $display("FAIL mid_reads: got %0d want 3", rd_pulses);
    else passes++;
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 8'd71)
      $display("FAIL mid_pre: m_valid %b m_data %0d want 1 / 71", bus.m_valid, bus.m_data);
    else passes++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_mon();
    checks++;
    if (bus.m_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", bus.m_valid);
    else passes++;
    bus.m_ready = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.m_valid !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet || rx.size() != 0) $display("FAIL mid_stale: got %0d stale words want 0", rx.size());
    else passes++;
    wr_data = 8'd99;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    wait_rx(1, 10);
    tick();
    checks++;
    if (rx.size() != 1 || rx[0] !== 8'd99)
      $display("FAIL mid_after: got %0d words first %0d want 1 / 99", rx.size(), (rx.size() > 0) ? rx[0] : 8'hxx);
    else passes++;
  endtask

`ifdef FIFO_RD_CNT_EN
  task automatic test_count();
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wr_data = 8'(i & 255);
      wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    wait_rx(300, 100);
    tick();
    checks++;
    if (bus.rd_count !== 8'd44) $display("FAIL cnt_wrap: got %0d want 44", bus.rd_count);
    else passes++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.rd_count !== 8'd0) $display("FAIL cnt_reset: got %0d want 0", bus.rd_count);
    else passes++;
  endtask
`endif

  initial begin
    bus.m_ready = 1'b0;
    test_reset();
    test_basic_drain();
    test_backpressure();
    test_throughput();
    test_random_stream();
    test_reset_mid();
`ifdef FIFO_RD_CNT_EN
    test_count();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, want completion");
    $fatal(1, "timeout");
  end

endmodule
